// File: rtl/person_counter_pkg.sv
// Shared definitions for the doorway person counter: crossing FSM encoding,
// parameter defaults and two-digit BCD helpers.
package person_counter_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_MAX_COUNT       = 99;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 1_000_000;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StInA       = 3'd1,
    StInAb      = 3'd2,
    StInB       = 3'd3,
    StOutB      = 3'd4,
    StOutBa     = 3'd5,
    StOutA      = 3'd6,
    StWaitClear = 3'd7
  } cross_state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  function automatic logic is_crossing(cross_state_t s);
    return (s != StIdle) && (s != StWaitClear);
  endfunction

  function automatic bcd2_t to_bcd(int unsigned n);
    bcd2_t r;
    r.tens = 4'(n / 10);
    r.ones = 4'(n % 10);
    return r;
  endfunction

  function automatic bcd2_t bcd_inc(bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd2_t bcd_dec(bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ones == 4'd0) begin
      r.ones = 4'd9;
      r.tens = v.tens - 4'd1;
    end else begin
      r.ones = v.ones - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a stability filter: the level output only
// follows the synchronized input after CYCLES consecutive differing samples.
module sensor_debounce #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int unsigned CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level   <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      if (sync2_q == level) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        level <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/person_counter.sv
// Doorway occupancy counter: two debounced beams drive a crossing FSM that
// increments/decrements a saturating two-digit BCD count.
module person_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = person_counter_pkg::DEF_DEBOUNCE_CYCLES,
  parameter int unsigned MAX_COUNT       = person_counter_pkg::DEF_MAX_COUNT,
  parameter int unsigned TIMEOUT_CYCLES  = person_counter_pkg::DEF_TIMEOUT_CYCLES
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic       SensorA,
  input  logic       SensorB,
  input  logic       Clear,
  output logic [3:0] PersonTens,
  output logic [3:0] PersonOnes,
  output logic       Full,
  output logic       Empty,
  output logic       Entered,
  output logic       Exited,
  output logic       Rejected
);
  import person_counter_pkg::*;

  localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam bcd2_t         MAX_BCD  = to_bcd(MAX_COUNT);
  localparam bcd2_t         BCD_ZERO = '0;

  logic          a, b;
  cross_state_t  state_q, state_d, fsm_next;
  logic [TW-1:0] tmo_q, tmo_d;
  bcd2_t         count_q, count_d;
  logic          inc_req, dec_req, ent_d, ext_d, rej_d;

  sensor_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk  (Clock),
    .rst_n(ResetN),
    .raw  (SensorA),
    .level(a)
  );

  sensor_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk  (Clock),
    .rst_n(ResetN),
    .raw  (SensorB),
    .level(b)
  );

  // Crossing table; the OUT_* states mirror IN_* with the beams swapped.
  always_comb begin
    fsm_next = state_q;
    inc_req  = 1'b0;
    dec_req  = 1'b0;
    unique case (state_q)
      StIdle: begin
        case ({a, b})
          2'b10:   fsm_next = StInA;
          2'b01:   fsm_next = StOutB;
          2'b11:   fsm_next = StWaitClear;
          default: ;
        endcase
      end
      StInA: begin
        case ({a, b})
          2'b11:   fsm_next = StInAb;
          2'b00:   fsm_next = StIdle;
          2'b01:   fsm_next = StWaitClear;
          default: ;
        endcase
      end
      StInAb: begin
        case ({a, b})
          2'b01:   fsm_next = StInB;
          2'b10:   fsm_next = StInA;
          2'b00:   fsm_next = StIdle;
          default: ;
        endcase
      end
      StInB: begin
        case ({a, b})
          2'b00: begin
            fsm_next = StIdle;
            inc_req  = 1'b1;
          end
          2'b11:   fsm_next = StInAb;
          2'b10:   fsm_next = StWaitClear;
          default: ;
        endcase
      end
      StOutB: begin
        case ({a, b})
          2'b11:   fsm_next = StOutBa;
          2'b00:   fsm_next = StIdle;
          2'b10:   fsm_next = StWaitClear;
          default: ;
        endcase
      end
      StOutBa: begin
        case ({a, b})
          2'b10:   fsm_next = StOutA;
          2'b01:   fsm_next = StOutB;
          2'b00:   fsm_next = StIdle;
          default: ;
        endcase
      end
      StOutA: begin
        case ({a, b})
          2'b00: begin
            fsm_next = StIdle;
            dec_req  = 1'b1;
          end
          2'b11:   fsm_next = StOutBa;
          2'b01:   fsm_next = StWaitClear;
          default: ;
        endcase
      end
      StWaitClear: begin
        if ({a, b} == 2'b00) fsm_next = StIdle;
      end
      default: fsm_next = StIdle;
    endcase
  end

  // Clear beats timeout, timeout beats any counting transition.
  always_comb begin
    state_d = fsm_next;
    tmo_d   = '0;
    count_d = count_q;
    ent_d   = 1'b0;
    ext_d   = 1'b0;
    rej_d   = 1'b0;
    if (Clear) begin
      state_d = StWaitClear;
      count_d = BCD_ZERO;
    end else if (is_crossing(state_q) && (tmo_q == TMO_LAST)) begin
      state_d = StWaitClear;
    end else begin
      if (is_crossing(state_q) && is_crossing(fsm_next)) tmo_d = tmo_q + 1'b1;
      if (inc_req) begin
        if (count_q == MAX_BCD) begin
          rej_d = 1'b1;
        end else begin
          count_d = bcd_inc(count_q);
          ent_d   = 1'b1;
        end
      end
      if (dec_req) begin
        if (count_q == BCD_ZERO) begin
          rej_d = 1'b1;
        end else begin
          count_d = bcd_dec(count_q);
          ext_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= StIdle;
      tmo_q    <= '0;
      count_q  <= BCD_ZERO;
      Full     <= 1'b0;
      Empty    <= 1'b1;
      Entered  <= 1'b0;
      Exited   <= 1'b0;
      Rejected <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      count_q  <= count_d;
      Full     <= (count_d == MAX_BCD);
      Empty    <= (count_d == BCD_ZERO);
      Entered  <= ent_d;
      Exited   <= ext_d;
      Rejected <= rej_d;
    end
  end

  assign PersonTens = count_q.tens;
  assign PersonOnes = count_q.ones;

endmodule

// File: doc/person_counter.md
PERSON_COUNTER -- requirements
Module: person_counter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required before a sensor level is accepted.
REQ-002 SHALL have parameter MAX_COUNT, default 99, occupancy saturation limit in binary (1..99).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, maximum cycles a crossing may stay in progress.
REQ-004 SHALL have port Clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port ResetN  input  1  one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port SensorA  input  1  outer door beam, high = broken, asynchronous to Clock.
REQ-007 SHALL have port SensorB  input  1  inner door beam, high = broken, asynchronous to Clock.
REQ-008 SHALL have port Clear  input  1  synchronous request to zero the occupancy count.
REQ-009 SHALL have port PersonTens  output  4  BCD tens digit of occupancy (0..9).
REQ-010 SHALL have port PersonOnes  output  4  BCD ones digit of occupancy (0..9).
REQ-011 SHALL have ports Full, Empty  output  1 each  count == MAX_COUNT; count == 0.
REQ-012 SHALL have ports Entered, Exited, Rejected  output  1 each  single-cycle event pulses.

Function
REQ-013 SHALL pass each sensor through a 2-flop synchronizer, then a debounce counter; debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples; raw-to-debounced latency = 2 + DEBOUNCE_CYCLES cycles.
REQ-014 SHALL run a crossing FSM on debounced (a,b) with states IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, WAIT_CLEAR.
REQ-015 IDLE: (1,0)->IN_A; (0,1)->OUT_B; (1,1)->WAIT_CLEAR; (0,0) stay.
REQ-016 IN_A: (1,1)->IN_AB; (0,0)->IDLE, no count; (0,1)->WAIT_CLEAR.
REQ-017 IN_AB: (0,1)->IN_B; (1,0)->IN_A; (0,0)->IDLE, no count.
REQ-018 IN_B: (0,0)->IDLE with increment request; (1,1)->IN_AB; (1,0)->WAIT_CLEAR.
REQ-019 OUT_B/OUT_BA/OUT_A SHALL mirror IN_A/IN_AB/IN_B with a and b swapped; OUT_A (0,0)->IDLE with decrement request.
REQ-020 WAIT_CLEAR: (0,0)->IDLE, no count; any other input stay.
REQ-021 SHALL count cycles spent outside IDLE/WAIT_CLEAR; on reaching TIMEOUT_CYCLES in one crossing force WAIT_CLEAR; counter zeroes on every return to IDLE.
REQ-022 Count SHALL be held as two BCD digits; increment: ones 9->0 with tens+1; decrement: ones 0->9 with tens-1; never non-BCD.
REQ-023 Count, flags and pulses SHALL update on the same edge the FSM takes the counting transition (registered outputs, zero added latency).
REQ-024 Increment at MAX_COUNT and decrement at 0 SHALL leave count unchanged and pulse Rejected instead of Entered/Exited.
REQ-025 Clear SHALL set count to 00 and force FSM to WAIT_CLEAR on the next edge; Clear wins over a simultaneous increment/decrement, with no event pulse.
REQ-026 Entered/Exited/Rejected SHALL each be high for exactly one cycle per event and mutually exclusive.

Reset
REQ-027 ResetN low SHALL asynchronously force FSM=IDLE, count=00, debounced levels=0, synchronizers=0, timeout=0, Entered=Exited=Rejected=0, Full=0, Empty=1.
REQ-028 Deassertion SHALL be taken synchronously; reset mid-crossing discards the crossing.

Structure
REQ-029 FSM state encodings and parameter defaults SHALL live in shared package person_counter_pkg for reuse by the downstream temperature selector.
REQ-030 Debounce SHALL be one sub-module, sensor_debounce, instantiated once per sensor.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64, MAX_COUNT=99)
REQ-031 Entry A, A+B, B, none (each held 10 cycles) from 00 -> 01, one Entered pulse, Empty falls.
REQ-032 Count 10, one exit sequence B, B+A, A, none -> 09 (tens/ones borrow), one Exited pulse.
REQ-033 Count 99, entry sequence -> stays 99, Full=1, one Rejected; count 00 exit -> stays 00, Rejected.
REQ-034 SensorA glitch 3 cycles wide -> FSM stays IDLE, no pulses; A then back to none -> no count.
REQ-035 Hold A+B 100 cycles mid-entry -> WAIT_CLEAR at cycle 64, release -> IDLE, count unchanged.
REQ-036 Clear asserted on the increment edge at count 42 -> 00, no Entered; ResetN low mid-crossing -> all reset values immediately.
